// File: rtl/t01_grid_renderer_if.sv
// rtl/t01_grid_renderer_if.sv - cell-store write and bulk-clear port of the grid renderer
interface t01_grid_renderer_if;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [3:0] wr_col;
  logic [2:0] wr_color;
  logic       clear_req;
  logic       busy;
  logic       clear_done;

  modport master (
    output wr_en, wr_row, wr_col, wr_color, clear_req,
    input  busy, clear_done
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_color, clear_req,
    output busy, clear_done
  );
endinterface

// File: rtl/t01_grid_renderer.sv
// rtl/t01_grid_renderer.sv - 10x20 cell board pixel source with border, write port and bulk clear
module t01_grid_renderer #(
  parameter int          GRID_X0  = 240,
  parameter int          GRID_Y0  = 80,
  parameter int          COLS     = 10,
  parameter int          ROWS     = 20,
  parameter int          BORDER   = 2,
  parameter logic [2:0]  BORDER_C = 3'b111,
  parameter logic [2:0]  BG_C     = 3'b000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              x_in,
  input  logic [9:0]              y_in,
  output logic [2:0]              color_out,
  t01_grid_renderer_if.slave      bus
);

  localparam logic signed [10:0] GX0    = 11'(GRID_X0);
  localparam logic signed [10:0] GY0    = 11'(GRID_Y0);
  localparam logic signed [10:0] BRD_W  = 11'(COLS * 16);
  localparam logic signed [10:0] BRD_H  = 11'(ROWS * 16);
  localparam logic signed [10:0] B_LO   = 11'(-BORDER);
  localparam logic signed [10:0] B_W_HI = 11'(COLS * 16 + BORDER);
  localparam logic signed [10:0] B_H_HI = 11'(ROWS * 16 + BORDER);
  localparam logic [4:0]         LAST_ROW = 5'(ROWS - 1);
  localparam logic [3:0]         LAST_COL = 4'(COLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic               clr_start, clr_last, done_d, done_q;
  logic [4:0]         clr_row;
  logic [3:0]         clr_col;

  logic [2:0]         cells [ROWS][COLS];

  logic [9:0]         x_q, y_q;
  logic signed [10:0] dx, dy;
  logic               in_board, in_outer, in_border;
  logic [4:0]         rd_row;
  logic [3:0]         rd_col;
  logic [2:0]         cell_val;
  logic               busy;
  logic               wr_ok;

  assign busy           = (state_q == CLEAR);
  assign bus.busy       = busy;
  assign bus.clear_done = done_q;

  // Pixel coordinates relative to cell (0,0); negative means left of / above the board.
  assign dx = $signed({1'b0, x_q}) - GX0;
  assign dy = $signed({1'b0, y_q}) - GY0;

  assign in_board  = (dx >= 11'sd0) && (dx < BRD_W) && (dy >= 11'sd0) && (dy < BRD_H);
  assign in_outer  = (dx >= B_LO) && (dx < B_W_HI) && (dy >= B_LO) && (dy < B_H_HI);
  assign in_border = in_outer && !in_board;

  // Off-board pixels would index past the store, so the read address is parked at (0,0).
  assign rd_row   = in_board ? dy[8:4] : 5'd0;
  assign rd_col   = in_board ? dx[7:4] : 4'd0;
  assign cell_val = cells[rd_row][rd_col];

  // A clear request in the same cycle takes priority, so the write is dropped.
  assign wr_ok = bus.wr_en && !busy && !bus.clear_req &&
                 (bus.wr_row < 5'(ROWS)) && (bus.wr_col < 4'(COLS));

  assign clr_last = (clr_row == LAST_ROW) && (clr_col == LAST_COL);

  // Stage 1 coordinate capture and stage 2 colour selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      color_out <= '0;
    end else begin
      x_q       <= x_in;
      y_q       <= y_in;
      color_out <= in_board ? cell_val : (in_border ? BORDER_C : BG_C);
    end
  end

  // Clear sequencer next-state: one cell per clock, finish pulse on the last cell.
  always_comb begin
    state_d   = state_q;
    clr_start = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d   = CLEAR;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear sequencer state, row-major cell cursor and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      clr_row <= '0;
      clr_col <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (clr_start) begin
        clr_row <= '0;
        clr_col <= '0;
      end else if (state_q == CLEAR) begin
        if (clr_col == LAST_COL) begin
          clr_col <= '0;
          clr_row <= clr_last ? 5'd0 : clr_row + 5'd1;
        end else begin
          clr_col <= clr_col + 4'd1;
        end
      end
    end
  end

  // Cell store: the clear cursor owns the store while busy, otherwise the write port does.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells[r][c] <= '0;
        end
      end
    end else if (state_q == CLEAR) begin
      cells[clr_row][clr_col] <= '0;
    end else if (wr_ok) begin
      cells[bus.wr_row][bus.wr_col] <= bus.wr_color;
    end
  end

endmodule

// File: tb/tb_t01_grid_renderer.sv
// tb/tb_t01_grid_renderer.sv - directed self-checking bench for the grid renderer
module tb_t01_grid_renderer;
  logic       clk;
  logic       rst;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic [2:0] color_out;

  int vectors;
  int miscompares;

  logic [2:0] ref_cells [20][10];

  t01_grid_renderer_if bus ();

  t01_grid_renderer dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .y_in      (y_in),
    .color_out (color_out),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [2:0] exp, input string tag);
    x_in = 10'(x);
    y_in = 10'(y);
    step();
    step();
    chk(tag, {29'd0, color_out}, {29'd0, exp});
  endtask

  task automatic wr(input int r, input int c, input logic [2:0] col);
    bus.wr_en    = 1'b1;
    bus.wr_row   = 5'(r);
    bus.wr_col   = 4'(c);
    bus.wr_color = col;
    step();
    bus.wr_en    = 1'b0;
    if (r < 20 && c < 10) ref_cells[r][c] = col;
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        pix(240 + 16 * c + 5, 80 + 16 * r + 9, ref_cells[r][c],
            $sformatf("%s r%0d c%0d", tag, r, c));
      end
    end
  endtask

  task automatic fill(input logic [2:0] col);
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        wr(r, c, col);
      end
    end
  endtask

  task automatic model_zero();
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        ref_cells[r][c] = 3'b000;
      end
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cyc;
    int done_cnt;

    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    x_in          = '0;
    y_in          = '0;
    bus.wr_en     = 1'b0;
    bus.wr_row    = '0;
    bus.wr_col    = '0;
    bus.wr_color  = '0;
    bus.clear_req = 1'b0;
    model_zero();

    // 1: reset state and background at (0,0)
    step();
    step();
    chk("reset color_out", {29'd0, color_out}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset clear_done", {31'd0, bus.clear_done}, 32'd0);
    rst = 1'b0;
    pix(0, 0, 3'b000, "origin bg");
    chk("idle busy", {31'd0, bus.busy}, 32'd0);
    chk("idle clear_done", {31'd0, bus.clear_done}, 32'd0);

    // 2: single cell write and its pixel extent
    wr(0, 0, 3'b100);
    pix(240, 80, 3'b100, "cell00 top-left");
    pix(255, 95, 3'b100, "cell00 bottom-right");
    pix(256, 80, 3'b000, "cell01 empty");

    // 3: border corners
    pix(238, 78, 3'b111, "border top-left");
    pix(237, 78, 3'b000, "bg left of border");
    pix(401, 401, 3'b111, "border bottom-right");
    pix(402, 401, 3'b000, "bg right of border");
    pix(239, 200, 3'b111, "border left edge");
    pix(300, 79, 3'b111, "border top edge");

    // 4: pattern fill, out-of-range writes dropped, full sweep
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        wr(r, c, 3'((r + 3 * c) % 8));
      end
    end
    wr(20, 0, 3'b101);
    wr(0, 10, 3'b101);
    wr(31, 15, 3'b101);
    wr(20, 10, 3'b101);
    sweep("pattern");

    // 5: fill, clear timing, write and second request during clear
    fill(3'b010);
    pix(240 + 16 * 9 + 1, 80 + 16 * 19 + 1, 3'b010, "filled last cell");
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 260; cyc++) begin
      if (bus.busy) busy_cnt++;
      if (bus.clear_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == 50) begin
        bus.wr_en     = 1'b1;
        bus.wr_row    = 5'd0;
        bus.wr_col    = 4'd0;
        bus.wr_color  = 3'b101;
        bus.clear_req = 1'b1;
      end else begin
        bus.wr_en     = 1'b0;
        bus.clear_req = 1'b0;
      end
      step();
    end
    model_zero();
    chk("clear busy cycles", busy_cnt, 32'd200);
    chk("clear_done cycle", done_cyc, 32'd201);
    chk("clear_done pulses", done_cnt, 32'd1);
    sweep("cleared");

    // 6: reset mid-clear
    fill(3'b010);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    repeat (49) step();
    chk("busy at cycle 50", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("busy after rst", {31'd0, bus.busy}, 32'd0);
    chk("clear_done after rst", {31'd0, bus.clear_done}, 32'd0);
    model_zero();
    done_cnt = 0;
    repeat (250) begin
      if (bus.clear_done) done_cnt++;
      step();
    end
    chk("no done after rst", done_cnt, 32'd0);
    sweep("post-rst");

    // 6: same-cycle clear request and write
    bus.clear_req = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_row    = 5'd19;
    bus.wr_col    = 4'd9;
    bus.wr_color  = 3'b110;
    step();
    bus.clear_req = 1'b0;
    bus.wr_en     = 1'b0;
    chk("busy after clear+wr", {31'd0, bus.busy}, 32'd1);
    pix(240 + 16 * 9 + 5, 80 + 16 * 19 + 5, 3'b000, "write lost to clear");
    done_cyc = 0;
    for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
      if (bus.clear_done) done_cyc = cyc;
      step();
    end
    chk("clear ran after clear+wr", {31'd0, done_cyc != 0}, 32'd1);
    wr(5, 5, 3'b011);
    pix(240 + 16 * 5, 80 + 16 * 5, 3'b011, "write after clear");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
